// File: rtl/arcade_input_map.sv
// Player-input front end: PS/2 key decode, joystick merge, rotation, opposite cleanup, coin stretch.
// Optional autofire on button 1 when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_map #(
  parameter int unsigned PLAYERS     = 2,
  parameter int unsigned BUTTONS     = 2,
  parameter int unsigned COIN_CYCLES = 4800000,
  parameter int unsigned AF_DIV      = 800000
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joystick,
  input  logic [1:0]             rotate,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [PLAYERS-1:0]     autofire,
`endif
  output logic [8*PLAYERS-1:0]   ctrl,
  output logic [PLAYERS-1:0]     start,
  output logic [PLAYERS-1:0]     coin,
  output logic                   service
);

  localparam int unsigned CW = $clog2(COIN_CYCLES + 1);

  typedef enum logic [2:0] {K_NONE, K_DIR, K_BTN, K_START, K_COIN, K_SERV} key_kind_e;

  key_kind_e   hit_kind;
  int unsigned hit_pl;
  int unsigned hit_idx;

  logic                             old_tgl_q, old_tgl_d;
  logic [PLAYERS-1:0][3:0]          kdir_q, kdir_d;
  logic [PLAYERS-1:0][BUTTONS-1:0]  kbtn_q, kbtn_d;
  logic [PLAYERS-1:0]               kstart_q, kstart_d;
  logic [PLAYERS-1:0]               kcoin_q, kcoin_d;
  logic                             kserv_q, kserv_d;
  logic [8*PLAYERS-1:0]             ctrl_q, ctrl_d;
  logic [PLAYERS-1:0]               start_q, start_d;
  logic                             service_q, service_d;
  logic [PLAYERS-1:0]               coin_prev_q, coin_prev_d;
  logic [PLAYERS-1:0][CW-1:0]       coin_cnt_q, coin_cnt_d;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AFW = $clog2(AF_DIV + 1);
  logic [PLAYERS-1:0][AFW-1:0]      af_cnt_q, af_cnt_d;
  logic [PLAYERS-1:0]               af_phase_q, af_phase_d;
`else
  localparam int unsigned af_div_unused = AF_DIV;
`endif

  logic [15:0]        joy_w;
  logic [3:0]         raw_dir, rot_dir;
  logic [BUTTONS-1:0] btn_w;
  logic               coin_raw;
  logic               unused_joy;

  assign unused_joy = ^joystick;

  always_comb begin
    hit_kind = K_NONE;
    hit_pl   = 0;
    hit_idx  = 0;
    case ({ps2_key[8], ps2_key[7:0]})
      9'h174: begin hit_kind = K_DIR;   hit_pl = 0; hit_idx = 0; end
      9'h16B: begin hit_kind = K_DIR;   hit_pl = 0; hit_idx = 1; end
      9'h172: begin hit_kind = K_DIR;   hit_pl = 0; hit_idx = 2; end
      9'h175: begin hit_kind = K_DIR;   hit_pl = 0; hit_idx = 3; end
      9'h014: begin hit_kind = K_BTN;   hit_pl = 0; hit_idx = 0; end
      9'h011: begin hit_kind = K_BTN;   hit_pl = 0; hit_idx = 1; end
      9'h029: begin hit_kind = K_BTN;   hit_pl = 0; hit_idx = 2; end
      9'h012: begin hit_kind = K_BTN;   hit_pl = 0; hit_idx = 3; end
      9'h034: begin hit_kind = K_DIR;   hit_pl = 1; hit_idx = 0; end
      9'h023: begin hit_kind = K_DIR;   hit_pl = 1; hit_idx = 1; end
      9'h02B: begin hit_kind = K_DIR;   hit_pl = 1; hit_idx = 2; end
      9'h02D: begin hit_kind = K_DIR;   hit_pl = 1; hit_idx = 3; end
      9'h01C: begin hit_kind = K_BTN;   hit_pl = 1; hit_idx = 0; end
      9'h01B: begin hit_kind = K_BTN;   hit_pl = 1; hit_idx = 1; end
      9'h015: begin hit_kind = K_BTN;   hit_pl = 1; hit_idx = 2; end
      9'h01D: begin hit_kind = K_BTN;   hit_pl = 1; hit_idx = 3; end
      9'h016: begin hit_kind = K_START; hit_pl = 0; end
      9'h01E: begin hit_kind = K_START; hit_pl = 1; end
      9'h026: begin hit_kind = K_START; hit_pl = 2; end
      9'h025: begin hit_kind = K_START; hit_pl = 3; end
      9'h02E: begin hit_kind = K_COIN;  hit_pl = 0; end
      9'h036: begin hit_kind = K_COIN;  hit_pl = 1; end
      9'h03D: begin hit_kind = K_COIN;  hit_pl = 2; end
      9'h03E: begin hit_kind = K_COIN;  hit_pl = 3; end
      9'h02C: begin hit_kind = K_SERV; end
      default: hit_kind = K_NONE;
    endcase
  end

  // Loops bounded by PLAYERS/BUTTONS drop keys for absent slots.
  always_comb begin
    old_tgl_d = ps2_key[10];
    kdir_d    = kdir_q;
    kbtn_d    = kbtn_q;
    kstart_d  = kstart_q;
    kcoin_d   = kcoin_q;
    kserv_d   = kserv_q;
    if (ps2_key[10] != old_tgl_q) begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        for (int unsigned d = 0; d < 4; d++)
          if (hit_kind == K_DIR && hit_pl == p && hit_idx == d) kdir_d[p][d] = ps2_key[9];
        for (int unsigned b = 0; b < BUTTONS; b++)
          if (hit_kind == K_BTN && hit_pl == p && hit_idx == b) kbtn_d[p][b] = ps2_key[9];
        if (hit_kind == K_START && hit_pl == p) kstart_d[p] = ps2_key[9];
        if (hit_kind == K_COIN && hit_pl == p) kcoin_d[p] = ps2_key[9];
      end
      if (hit_kind == K_SERV) kserv_d = ps2_key[9];
    end
  end

  always_comb begin
    ctrl_d      = '0;
    start_d     = '0;
    service_d   = kserv_q;
    coin_prev_d = coin_prev_q;
    coin_cnt_d  = coin_cnt_q;
    joy_w       = '0;
    raw_dir     = '0;
    rot_dir     = '0;
    btn_w       = '0;
    coin_raw    = 1'b0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    af_cnt_d    = af_cnt_q;
    af_phase_d  = af_phase_q;
`endif
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      joy_w   = joystick[16*p +: 16];
      raw_dir = kdir_q[p] | joy_w[3:0];
      btn_w   = kbtn_q[p] | joy_w[4 +: BUTTONS];
      case (rotate)
        2'd1:    rot_dir = {raw_dir[1], raw_dir[0], raw_dir[2], raw_dir[3]};
        2'd2:    rot_dir = {raw_dir[2], raw_dir[3], raw_dir[0], raw_dir[1]};
        2'd3:    rot_dir = {raw_dir[0], raw_dir[1], raw_dir[3], raw_dir[2]};
        default: rot_dir = raw_dir;
      endcase
      if (rot_dir[3] && rot_dir[2]) rot_dir[3:2] = 2'b00;
      if (rot_dir[1] && rot_dir[0]) rot_dir[1:0] = 2'b00;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      // Phase parks at 1 while released so a fresh press fires at once.
      if (autofire[p] && btn_w[0]) begin
        btn_w[0] = af_phase_q[p];
        if (af_cnt_q[p] == AFW'(AF_DIV - 1)) begin
          af_cnt_d[p]   = '0;
          af_phase_d[p] = ~af_phase_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] + 1'b1;
        end
      end else begin
        af_cnt_d[p]   = '0;
        af_phase_d[p] = 1'b1;
      end
`else
      btn_w[0] = btn_w[0];
`endif
      ctrl_d[8*p +: 4]         = rot_dir;
      ctrl_d[8*p+4 +: BUTTONS] = btn_w;
      start_d[p]  = kstart_q[p] | joy_w[4+BUTTONS];
      coin_raw    = kcoin_q[p] | joy_w[5+BUTTONS];
      coin_prev_d[p] = coin_raw;
      if (coin_cnt_q[p] != '0)
        coin_cnt_d[p] = coin_cnt_q[p] - 1'b1;
      else if (coin_raw && !coin_prev_q[p])
        coin_cnt_d[p] = CW'(COIN_CYCLES);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_tgl_q   <= 1'b0;
      kdir_q      <= '0;
      kbtn_q      <= '0;
      kstart_q    <= '0;
      kcoin_q     <= '0;
      kserv_q     <= 1'b0;
      ctrl_q      <= '0;
      start_q     <= '0;
      service_q   <= 1'b0;
      coin_prev_q <= '0;
      coin_cnt_q  <= '0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      af_cnt_q    <= '0;
      af_phase_q  <= '1;
`endif
    end else begin
      old_tgl_q   <= old_tgl_d;
      kdir_q      <= kdir_d;
      kbtn_q      <= kbtn_d;
      kstart_q    <= kstart_d;
      kcoin_q     <= kcoin_d;
      kserv_q     <= kserv_d;
      ctrl_q      <= ctrl_d;
      start_q     <= start_d;
      service_q   <= service_d;
      coin_prev_q <= coin_prev_d;
      coin_cnt_q  <= coin_cnt_d;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      af_cnt_q    <= af_cnt_d;
      af_phase_q  <= af_phase_d;
`endif
    end
  end

  always_comb begin
    coin = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) coin[p] = (coin_cnt_q[p] != '0);
  end

  assign ctrl    = ctrl_q;
  assign start   = start_q;
  assign service = service_q;

endmodule

// File: tb/tb_arcade_input_map.sv
// Bench for arcade_input_map: vector table, hand-written timing sequences, random run against a model.
module tb_arcade_input_map;
  localparam int unsigned PL  = 2;
  localparam int unsigned BT  = 2;
  localparam int unsigned CC  = 5;
  localparam int unsigned AFD = 3;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic [1:0]  rotate;
  logic [1:0]  autofire;
  logic [15:0] ctrl;
  logic [1:0]  start;
  logic [1:0]  coin;
  logic        service;

  arcade_input_map #(.PLAYERS(PL), .BUTTONS(BT), .COIN_CYCLES(CC), .AF_DIV(AFD)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .joystick (joystick),
    .rotate   (rotate),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire (autofire),
`endif
    .ctrl     (ctrl),
    .start    (start),
    .coin     (coin),
    .service  (service)
  );

  always #5 clk_sys = ~clk_sys;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state
  bit          kstate [512];
  bit          m_old_tgl;
  int          coin_left [2];
  bit          coin_prev [2];
  int          af_n [2];
  bit          model_on = 1'b0;
  logic [15:0] exp_ctrl;
  logic [1:0]  exp_start, exp_coin;
  logic        exp_service;

  int dir_code   [2][4] = '{'{'h174, 'h16B, 'h172, 'h175}, '{'h034, 'h023, 'h02B, 'h02D}};
  int btn_code   [2][2] = '{'{'h014, 'h011}, '{'h01C, 'h01B}};
  int start_code [2]    = '{'h016, 'h01E};
  int coin_code  [2]    = '{'h02E, 'h036};
  // Directions as quarter turns counter-clockwise from right: R=0, U=1, L=2, D=3.
  int angle_of_bit [4]  = '{0, 2, 3, 1};
  int bit_of_angle [4]  = '{0, 3, 1, 2};

  task automatic model_edge();
    logic [3:0] raw, outd;
    logic [1:0] btn;
    bit rc;
    for (int p = 0; p < 2; p++) begin
      outd = '0;
      for (int d = 0; d < 4; d++) begin
        raw[d] = kstate[dir_code[p][d]] | joystick[16*p + d];
        if (raw[d]) outd[bit_of_angle[(angle_of_bit[d] + 4 - int'(rotate)) % 4]] = 1'b1;
      end
      if (outd[3] && outd[2]) outd[3:2] = 2'b00;
      if (outd[1] && outd[0]) outd[1:0] = 2'b00;
      for (int b = 0; b < 2; b++) btn[b] = kstate[btn_code[p][b]] | joystick[16*p + 4 + b];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      if (autofire[p] && btn[0]) begin
        btn[0] = ((af_n[p] / AFD) % 2) == 0;
        af_n[p]++;
      end else begin
        af_n[p] = 0;
      end
`endif
      exp_ctrl[8*p +: 8] = {2'b00, btn, outd};
      exp_start[p] = kstate[start_code[p]] | joystick[16*p + 6];
      rc = kstate[coin_code[p]] | joystick[16*p + 7];
      if (coin_left[p] > 0) coin_left[p]--;
      else if (rc && !coin_prev[p]) coin_left[p] = CC;
      coin_prev[p] = rc;
      exp_coin[p] = (coin_left[p] != 0);
    end
    exp_service = kstate['h02C];
    if (ps2_key[10] != m_old_tgl) kstate[int'({ps2_key[8], ps2_key[7:0]})] = ps2_key[9];
    m_old_tgl = ps2_key[10];
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (model_on) model_edge();
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  typedef struct {
    logic [15:0] joy;
    logic [1:0]  rot;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [13];
  int   rnd_codes [14] = '{'h175, 'h172, 'h16B, 'h174, 'h014, 'h011, 'h02D, 'h01C,
                           'h016, 'h02E, 'h02C, 'h026, 'h075, 'h000};

  initial begin
    int hi, first, runs;
    logic prev;
    logic [11:0] pat;
    logic p2_steady;

    reset = 1'b1; ps2_key = '0; joystick = '0; rotate = 2'd0; autofire = 2'b00;

    tbl[0]  = '{16'h0002, 2'd0, 8'h02};
    tbl[1]  = '{16'h0002, 2'd1, 8'h08};
    tbl[2]  = '{16'h0002, 2'd2, 8'h01};
    tbl[3]  = '{16'h0002, 2'd3, 8'h04};
    tbl[4]  = '{16'h0008, 2'd1, 8'h01};
    tbl[5]  = '{16'h0008, 2'd3, 8'h02};
    tbl[6]  = '{16'h0004, 2'd2, 8'h08};
    tbl[7]  = '{16'h000C, 2'd0, 8'h00};
    tbl[8]  = '{16'h000F, 2'd0, 8'h00};
    tbl[9]  = '{16'h001A, 2'd0, 8'h1A};
    tbl[10] = '{16'h0005, 2'd1, 8'h06};
    tbl[11] = '{16'h0020, 2'd0, 8'h20};
    tbl[12] = '{16'hFF40, 2'd0, 8'h00};

    repeat (2) @(posedge clk_sys);
    #1;
    check("reset_outputs", {ctrl, start, coin, service}, '0);
    reset = 1'b0;
    tick();
    check("idle_outputs", {ctrl, start, coin, service}, '0);

    // Keyboard up: key state at edge k, output at k+1
    send_key(1'b1, 9'h175);
    tick(); check("kbd_up_edge_k", ctrl[3], 1'b0);
    tick(); check("kbd_up_edge_k1", ctrl[7:0], 8'h08);
    send_key(1'b0, 9'h175);
    tick(); check("kbd_rel_edge_k", ctrl[3], 1'b1);
    tick(); check("kbd_rel_edge_k1", ctrl[7:0], 8'h00);

    for (int i = 0; i < 13; i++) begin
      joystick[15:0] = tbl[i].joy;
      rotate = tbl[i].rot;
      tick();
      check($sformatf("vec%0d", i), ctrl[7:0], tbl[i].exp);
    end
    joystick = '0; rotate = 2'd0;
    tick();
    check("start_from_vec12", start, 2'b00);
    joystick[22] = 1'b1;
    tick(); check("p2_start_joy", start, 2'b10);
    joystick = '0;

    send_key(1'b1, 9'h02C);
    tick(); tick(); check("service_key", service, 1'b1);
    send_key(1'b0, 9'h02C);
    tick(); tick(); check("service_rel", service, 1'b0);

    // Opposite cleanup: keyboard up with joystick down
    send_key(1'b1, 9'h175);
    joystick[2] = 1'b1;
    tick(); tick(); check("opposite_both", ctrl[3:2], 2'b00);
    joystick[2] = 1'b0;
    tick(); check("opposite_down_rel", ctrl[3:2], 2'b10);
    send_key(1'b0, 9'h175);
    tick(); tick();

    // Coin held 20 cycles
    send_key(1'b1, 9'h02E);
    hi = 0; first = 0; runs = 0; prev = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (coin[0]) begin hi++; if (first == 0) first = i; end
      if (coin[0] && !prev) runs++;
      prev = coin[0];
    end
    check("coin_held_len", hi, 5);
    check("coin_held_first", first, 2);
    check("coin_held_runs", runs, 1);
    send_key(1'b0, 9'h02E);
    repeat (3) tick();
    send_key(1'b1, 9'h02E);
    hi = 0;
    repeat (12) begin tick(); if (coin[0]) hi++; end
    check("coin_second_len", hi, 5);
    send_key(1'b0, 9'h02E);
    repeat (8) tick();

    // Second raw edge inside an active pulse
    hi = 0; runs = 0; prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      joystick[7] = (i == 0 || i == 2);
      tick();
      if (coin[0]) hi++;
      if (coin[0] && !prev) runs++;
      prev = coin[0];
    end
    check("coin_retrig_len", hi, 5);
    check("coin_retrig_runs", runs, 1);
    joystick = '0;

    // Reset mid pulse with coin key held; leave toggle at 0 so release makes no event
    if (ps2_key[10] == 1'b0) send_key(1'b0, 9'h000);
    tick();
    send_key(1'b1, 9'h02E);
    repeat (3) tick();
    check("coin_before_reset", coin[0], 1'b1);
    reset = 1'b1;
    #1;
    check("reset_async", {ctrl, start, coin, service}, '0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    hi = 0;
    repeat (8) begin tick(); if (coin[0]) hi++; end
    check("held_after_reset", hi, 0);
    send_key(1'b1, 9'h02E);
    hi = 0;
    repeat (10) begin tick(); if (coin[0]) hi++; end
    check("coin_after_new_make", hi, 5);
    send_key(1'b0, 9'h02E);
    repeat (8) tick();

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    autofire = 2'b01;
    tick(); tick();
    joystick[4] = 1'b1; joystick[20] = 1'b1;
    pat = '0; p2_steady = 1'b1;
    repeat (12) begin
      tick();
      pat = {pat[10:0], ctrl[4]};
      p2_steady &= ctrl[12];
    end
    check("af_p1_pattern", pat, 12'b111000111000);
    check("af_p2_steady", p2_steady, 1'b1);
    joystick = '0; autofire = 2'b00;
    tick();
`endif

    // Random run against the model
    reset = 1'b1; ps2_key = '0; joystick = '0; rotate = 2'd0; autofire = 2'b00;
    tick();
    foreach (kstate[i]) kstate[i] = 1'b0;
    m_old_tgl = 1'b0;
    for (int p = 0; p < 2; p++) begin coin_left[p] = 0; coin_prev[p] = 1'b0; af_n[p] = 0; end
    reset = 1'b0;
    model_on = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) joystick[$urandom_range(0, 31)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) joystick = '0;
      if ($urandom_range(0, 3) == 0)
        send_key(1'($urandom_range(0, 1)), 9'(rnd_codes[$urandom_range(0, 13)]));
      if ($urandom_range(0, 15) == 0) rotate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) autofire = 2'($urandom_range(0, 3));
      tick();
      check("rnd_ctrl", ctrl, exp_ctrl);
      check("rnd_start", start, exp_start);
      check("rnd_coin", coin, exp_coin);
      check("rnd_service", service, exp_service);
    end
    model_on = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
